mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Parametrised successor to the single-word memory access wrapper. It sequences reads and writes to a synchronous single-port RAM through a level start/done handshake.
- Adds configurable data/address width, configurable access latency, multi-beat bursts with per-beat acknowledge, synchronous reset, a busy flag, and out-of-range burst detection.
- Sits between the coprocessor control FSM and the on-chip data RAM.

Parameters:
- DATA_W, 16: RAM word width.
- ADDR_W, 8: RAM address width. Depth = 2**ADDR_W.
- LAT, 3: cycles per beat, from address issue to data capture. Must be >= 2; elaboration fails otherwise.
- BURST_W, 4: width of burst_len. Maximum burst = 2**BURST_W beats.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: level request. Sampled only in IDLE.
- wr, input, 1: 1 = write burst, 0 = read burst. Latched at start.
- address, input, ADDR_W: base address. Latched at start.
- burst_len, input, BURST_W: beats minus one. Latched at start.
- data_in, input, DATA_W: write data for the current beat.
- data_out, output, DATA_W: read data of the most recent completed read beat.
- beat_ack, output, 1: one-cycle pulse at the end of each beat.
- busy, output, 1: high in ACCESS.
- done, output, 1: high in DONE.
- error, output, 1: burst rejected as out of range. Valid while done=1.

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE; data_out=0; beat_ack=0; busy=0; done=0; error=0; beat and wait counters=0; RAM write enable=0.
  - Reset wins over every other input.
  - Reset mid-burst aborts the burst. RAM words already written stay written; no further write occurs.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - start=1 at an edge latches wr, address and burst_len; sets N = burst_len+1.
  - Range check: if address + burst_len > 2**ADDR_W - 1 (computed in ADDR_W+1 bits), go to DONE with error=1. No RAM access occurs.
  - Otherwise go to ACCESS with beat=0, wait=0.
- ACCESS, per beat:
  - RAM address = base + beat.
  - wait=0: for writes, RAM write enable=1 for this cycle only, writing data_in.
  - wait=LAT-1: for reads, data_out <= RAM output. beat_ack=1 at the following edge for one cycle.
  - beat < N-1: beat increments and wait clears.
  - Last beat: go to DONE with error=0.
- Timing, start sampled at edge 0:
  - Beat k ends at edge (k+1)*LAT.
  - done and the final data_out are visible after edge N*LAT.
  - Total latency = N*LAT cycles.
- Write data rule:
  - Beat 0 uses data_in present on the cycle after start is sampled.
  - The master advances data_in at the edge where it observes beat_ack=1.
  - data_in is ignored at all other times.
- DONE:
  - done stays high while start=1.
  - start=0 at an edge returns to IDLE; done and error clear.
  - A new request therefore needs start to drop for at least one cycle.
- Input changes on wr, address and burst_len outside IDLE are ignored.
- data_out holds its value across bursts. It changes only on read-beat capture or reset.
- busy and done are never high together. beat_ack is never high in IDLE.
- No address wrap-around: a burst ending exactly at 2**ADDR_W - 1 is legal; one word beyond it sets error.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/DONE), the default width constants DATA_W/ADDR_W/BURST_W, and LAT_MIN=2.
- One sub-module: ram_sp_sync, a parametrised single-port RAM.
  - Ports: clk, addr, din, we, dout.
  - Registered address, read-first behaviour.
  - Instantiated once. The controller counts LAT from that instance's fixed internal latency.

Test Plan:
- Single read: preload RAM[0x10]=0xBEEF; start, wr=0, address=0x10, burst_len=0, LAT=3 -> beat_ack at cycle 3; done and data_out=0xBEEF at cycle 3; busy high for cycles 1-3.
- Burst write then read: write 4 beats at 0x20 with data 0x1111/0x2222/0x3333/0x4444, advancing on beat_ack -> done at cycle 12. Read back 4 beats -> beat_ack x4 with data_out sequence matching.
- Boundary: address=0xFC, burst_len=3 -> legal, 4 beats, error=0. address=0xFD, burst_len=3 -> done at cycle 1 with error=1, RAM contents unchanged, beat_ack never asserted.
- Handshake hold: keep start=1 for 10 cycles after done -> done stays high, no second burst. Drop start for one cycle, then raise it -> a new burst starts.
- Reset mid-burst: 8-beat write, assert reset after the 2nd beat_ack -> next cycle all outputs are 0 and state is IDLE; only the first 2 (or 3, if beat 2's wait=0 cycle has passed) words are written.
- Ignored inputs: change address and wr during ACCESS -> the burst completes with the latched values.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst memory controller: FSM encoding,
// default widths and the latency floor set by the RAM read port.
package mem_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_BURST_W = 4;

  // The RAM returns data one edge after the address is registered, so a
  // beat needs at least one extra cycle before capture.
  localparam int RAM_RD_LAT = 1;
  localparam int LAT_MIN    = 2;

endpackage : mem_burst_ctrl_pkg

// File: rtl/mem_burst_ctrl_if.sv
// Request/response bundle between the coprocessor control FSM (master)
// and the burst controller (slave).
interface mem_burst_ctrl_if
  import mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BURST_W = DEFAULT_BURST_W
);

  logic               start;
  logic               wr;
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burst_len;
  logic [DATA_W-1:0]  data_in;
  logic [DATA_W-1:0]  data_out;
  logic               beat_ack;
  logic               busy;
  logic               done;
  logic               error;

  modport master (
    output start, wr, address, burst_len, data_in,
    input  data_out, beat_ack, busy, done, error
  );

  modport slave (
    input  start, wr, address, burst_len, data_in,
    output data_out, beat_ack, busy, done, error
  );

endinterface : mem_burst_ctrl_if

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, read-first: the registered read port returns
// the word held before any write on the same edge.
module ram_sp_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // only defined once written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout <= mem_q[addr];
  end

endmodule : ram_sp_sync

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for a single-port synchronous RAM: latches a request,
// range-checks it, then runs N beats of LAT cycles each with a per-beat ack.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int LAT     = 3,
  parameter int BURST_W = DEFAULT_BURST_W
) (
  input logic               clk,
  input logic               reset,
  mem_burst_ctrl_if.slave   bus
);

  localparam int WAIT_W = (LAT > 2) ? $clog2(LAT) : 1;

  if (LAT < LAT_MIN || LAT - 1 < RAM_RD_LAT) begin : g_lat_check
    $error("mem_burst_ctrl: LAT must be at least LAT_MIN");
  end

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               beat_ack_q, beat_ack_d;
  logic               error_q, error_d;

  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_dout;
  logic [ADDR_W:0]    last_addr;
  logic               range_err;

  // One extra bit catches a burst that would run past the top word.
  assign last_addr = {1'b0, bus.address} + (ADDR_W+1)'(bus.burst_len);
  assign range_err = last_addr[ADDR_W];

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so
    // no path through the case below can leave one unassigned (no latches).
    state_d    = state_q;
    wr_d       = wr_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_cnt_d = wait_cnt_q;
    data_out_d = data_out_q;
    beat_ack_d = 1'b0;
    error_d    = error_q;
    ram_we     = 1'b0;
    ram_addr   = base_q + ADDR_W'(beat_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          wr_d       = bus.wr;
          base_d     = bus.address;
          len_d      = bus.burst_len;
          beat_d     = '0;
          wait_cnt_d = '0;
          error_d    = range_err;
          state_d    = range_err ? ST_DONE : ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Reset must suppress the write that would otherwise land on this edge.
        ram_we = wr_q && (wait_cnt_q == '0) && !reset;
        if (wait_cnt_q == WAIT_W'(LAT - 1)) begin
          beat_ack_d = 1'b1;
          if (!wr_q) begin
            data_out_d = ram_dout;
          end
          if (beat_q == len_q) begin
            error_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            beat_d     = beat_q + 1'b1;
            wait_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (!bus.start) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_cnt_q <= '0;
      data_out_q <= '0;
      beat_ack_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wait_cnt_q <= wait_cnt_d;
      data_out_q <= data_out_d;
      beat_ack_q <= beat_ack_d;
      error_q    <= error_d;
    end
  end

  ram_sp_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .din  (bus.data_in),
    .we   (ram_we),
    .dout (ram_dout)
  );

  assign bus.data_out = data_out_q;
  assign bus.beat_ack = beat_ack_q;
  assign bus.busy     = (state_q == ST_ACCESS);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.error    = error_q;

endmodule : mem_burst_ctrl

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: reset, single and burst transfers,
// range boundary, start/done handshake, mid-burst reset and ignored inputs.
module tb_mem_burst_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int BURST_W = 4;
  localparam int LAT     = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  mem_burst_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LAT     (LAT),
    .BURST_W (BURST_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int overlap_cnt = 0;

  logic [DATA_W-1:0] wbuf [16];
  logic [DATA_W-1:0] rbuf [16];
  int                ack_cyc [16];
  int                acks;
  int                done_cyc;
  int                busy_cnt;

  // Drives one request and follows it to done (bounded); cycle c counts edges
  // after the edge that samples start. Optionally perturbs the request inputs
  // once the request has been taken.
  task automatic run_burst(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [BURST_W-1:0] len, input bit scramble);
    int c;
    bus.start     = 1'b1;
    bus.wr        = w;
    bus.address   = a;
    bus.burst_len = len;
    bus.data_in   = wbuf[0];
    acks = 0; done_cyc = 0; busy_cnt = 0; c = 0;
    @(posedge clk); #1;
    if (scramble) begin
      bus.wr        = ~w;
      bus.address   = 8'h10;
      bus.burst_len = '0;
    end
    while (done_cyc == 0 && c < 200) begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) overlap_cnt++;
      @(posedge clk); #1;
      c++;
      if (bus.beat_ack) begin
        if (acks < 16) begin
          rbuf[acks]    = bus.data_out;
          ack_cyc[acks] = c;
        end
        acks++;
        if (acks <= int'(len)) bus.data_in = wbuf[acks];
      end
      if (bus.done) done_cyc = c;
    end
  endtask

  task automatic release_start();
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
    n_checks++;
    if ({bus.beat_ack, bus.busy, bus.done, bus.error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got ack/busy/done/err=%b want 0000",
                         {bus.beat_ack, bus.busy, bus.done, bus.error});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    wbuf[0] = 16'hBEEF;
    run_burst(1'b1, 8'h10, 4'd0, 1'b0);
    n_checks++;
    if (done_cyc !== 3) begin n_fail++; $display("FAIL single_wr_done: got %0d want 3", done_cyc); end
    release_start();
    run_burst(1'b0, 8'h10, 4'd0, 1'b0);
    n_checks++;
    if (acks !== 1 || ack_cyc[0] !== 3) begin
      n_fail++; $display("FAIL single_rd_ack: got acks=%0d cyc=%0d want 1/3", acks, ack_cyc[0]);
    end
    n_checks++;
    if (done_cyc !== 3) begin n_fail++; $display("FAIL single_rd_done: got %0d want 3", done_cyc); end
    n_checks++;
    if (bus.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL single_rd_data: got %h want beef", bus.data_out); end
    n_checks++;
    if (busy_cnt !== 3) begin n_fail++; $display("FAIL single_rd_busy: got %0d cycles want 3", busy_cnt); end
    n_checks++;
    if (bus.error !== 1'b0) begin n_fail++; $display("FAIL single_rd_error: got %b want 0", bus.error); end
    release_start();
  endtask

  task automatic test_burst_wr_rd();
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    run_burst(1'b1, 8'h20, 4'd3, 1'b0);
    n_checks++;
    if (done_cyc !== 12 || acks !== 4) begin
      n_fail++; $display("FAIL burst_wr: got done=%0d acks=%0d want 12/4", done_cyc, acks);
    end
    release_start();
    run_burst(1'b0, 8'h20, 4'd3, 1'b0);
    n_checks++;
    if (done_cyc !== 12 || acks !== 4) begin
      n_fail++; $display("FAIL burst_rd: got done=%0d acks=%0d want 12/4", done_cyc, acks);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rbuf[k] !== wbuf[k] || ack_cyc[k] !== 3 * (k + 1)) begin
        n_fail++; $display("FAIL burst_rd_beat%0d: got %h@%0d want %h@%0d",
                           k, rbuf[k], ack_cyc[k], wbuf[k], 3 * (k + 1));
      end
    end
    release_start();
  endtask

  task automatic test_boundary();
    wbuf[0] = 16'hC0C0; wbuf[1] = 16'hC1C1; wbuf[2] = 16'hC2C2; wbuf[3] = 16'hC3C3;
    run_burst(1'b1, 8'hFC, 4'd3, 1'b0);
    n_checks++;
    if (done_cyc !== 12 || acks !== 4 || bus.error !== 1'b0) begin
      n_fail++; $display("FAIL bound_legal: got done=%0d acks=%0d err=%b want 12/4/0",
                         done_cyc, acks, bus.error);
    end
    release_start();
    wbuf[0] = 16'hDEAD; wbuf[1] = 16'hDEAD; wbuf[2] = 16'hDEAD; wbuf[3] = 16'hDEAD;
    run_burst(1'b1, 8'hFD, 4'd3, 1'b0);
    n_checks++;
    if (done_cyc !== 1 || acks !== 0 || bus.error !== 1'b1) begin
      n_fail++; $display("FAIL bound_reject: got done=%0d acks=%0d err=%b want 1/0/1",
                         done_cyc, acks, bus.error);
    end
    release_start();
    n_checks++;
    if (bus.error !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL bound_err_clear: got err=%b done=%b want 0/0", bus.error, bus.done);
    end
    run_burst(1'b0, 8'hFD, 4'd2, 1'b0);
    n_checks++;
    if (rbuf[0] !== 16'hC1C1 || rbuf[1] !== 16'hC2C2 || rbuf[2] !== 16'hC3C3 || acks !== 3) begin
      n_fail++; $display("FAIL bound_unchanged: got %h %h %h acks=%0d want c1c1 c2c2 c3c3 3",
                         rbuf[0], rbuf[1], rbuf[2], acks);
    end
    release_start();
  endtask

  task automatic test_handshake_hold();
    int bad;
    run_burst(1'b0, 8'h10, 4'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.beat_ack !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL hold_done: got %0d bad cycles want 0", bad); end
    release_start();
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hold_release: got done=%b want 0", bus.done); end
    run_burst(1'b0, 8'h20, 4'd0, 1'b0);
    n_checks++;
    if (done_cyc !== 3 || rbuf[0] !== 16'h1111) begin
      n_fail++; $display("FAIL hold_restart: got done=%0d data=%h want 3/1111", done_cyc, rbuf[0]);
    end
    release_start();
  endtask

  task automatic test_reset_mid_burst();
    int c;
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h0A00 + 16'(i);
    run_burst(1'b1, 8'h40, 4'd7, 1'b0);
    release_start();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'hB000 + 16'(i);
    bus.start = 1'b1; bus.wr = 1'b1; bus.address = 8'h40; bus.burst_len = 4'd7;
    bus.data_in = wbuf[0];
    acks = 0; c = 0;
    @(posedge clk); #1;
    while (acks < 2 && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (bus.beat_ack) begin
        acks++;
        bus.data_in = wbuf[acks];
      end
    end
    n_checks++;
    if (c !== 6) begin n_fail++; $display("FAIL rst_mid_ack2: got cycle %0d want 6", c); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.data_out, bus.beat_ack, bus.busy, bus.done, bus.error} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got data=%h ack/busy/done/err=%b want 0",
                         bus.data_out, {bus.beat_ack, bus.busy, bus.done, bus.error});
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    run_burst(1'b0, 8'h40, 4'd3, 1'b0);
    n_checks++;
    if (rbuf[0] !== 16'hB000 || rbuf[1] !== 16'hB001 || rbuf[2] !== 16'h0A02 || rbuf[3] !== 16'h0A03) begin
      n_fail++; $display("FAIL rst_mid_ram: got %h %h %h %h want b000 b001 0a02 0a03",
                         rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
    release_start();
  endtask

  task automatic test_ignored_inputs();
    wbuf[0] = 16'h6001; wbuf[1] = 16'h6002;
    run_burst(1'b1, 8'h60, 4'd1, 1'b1);
    n_checks++;
    if (done_cyc !== 6 || acks !== 2) begin
      n_fail++; $display("FAIL ignore_len: got done=%0d acks=%0d want 6/2", done_cyc, acks);
    end
    release_start();
    run_burst(1'b0, 8'h60, 4'd1, 1'b0);
    n_checks++;
    if (rbuf[0] !== 16'h6001 || rbuf[1] !== 16'h6002) begin
      n_fail++; $display("FAIL ignore_data: got %h %h want 6001 6002", rbuf[0], rbuf[1]);
    end
    release_start();
    run_burst(1'b0, 8'h10, 4'd0, 1'b0);
    n_checks++;
    if (rbuf[0] !== 16'hBEEF) begin n_fail++; $display("FAIL ignore_addr: got %h want beef", rbuf[0]); end
    release_start();
  endtask

  initial begin
    bus.start = 1'b0; bus.wr = 1'b0; bus.address = '0; bus.burst_len = '0; bus.data_in = '0;
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_burst_wr_rd();
    test_boundary();
    test_handshake_hold();
    test_reset_mid_burst();
    test_ignored_inputs();
    n_checks++;
    if (overlap_cnt !== 0) begin n_fail++; $display("FAIL busy_done_overlap: got %0d want 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_burst_ctrl
